// File: rtl/instr_pkg.sv
// Shared types for the instruction issuer: the 9-bit decoder instruct word and the issue FSM states.
package instr_pkg;

  localparam int unsigned SEL_W = 3;
  localparam int unsigned OP_W  = 3;

  // Field order matches the decoder's instruct bus: op[8:6], dst[5:3], src[2:0]
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [SEL_W-1:0] dst;
    logic [SEL_W-1:0] src;
  } instr_t;

  localparam int unsigned INSTR_W = $bits(instr_t);

  localparam instr_t INSTR_NOP = '0;

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

endpackage

// File: rtl/instr_fifo.sv
// Show-ahead FIFO with a separate occupancy count so full and empty are never ambiguous.
module instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_issuer.sv
// Queue-driven issuer: buffers instruction fields and drives each packed word onto the
// decoder's instruct bus for max(hold,1) cycles, back-to-back when more work is queued.
module instruction_issuer
  import instr_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned HOLD_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_src,
  input  logic [SEL_W-1:0]         in_dst,
  input  logic [OP_W-1:0]          in_op,
  input  logic [HOLD_W-1:0]        in_hold,
  output logic [INSTR_W-1:0]       instruct,
  output logic                     issue_busy,
  output logic                     issue_pulse,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned ENTRY_W = INSTR_W + HOLD_W;

  instr_t              in_word;
  instr_t              head_word;
  logic [HOLD_W-1:0]   head_hold;
  logic [ENTRY_W-1:0]  head_entry;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;

  state_t              state_q;
  state_t              state_d;
  instr_t              instr_q;
  instr_t              instr_d;
  logic                busy_d;
  logic                pulse_d;
  logic [HOLD_W-1:0]   cnt_q;
  logic [HOLD_W-1:0]   cnt_d;

  assign in_word  = {in_op, in_dst, in_src};
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready && !flush;
  assign {head_word, head_hold} = head_entry;
  assign instruct = instr_q;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({in_word, in_hold}),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-state and output decode; a zero hold loads the counter as if hold were 1
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    busy_d  = issue_busy;
    pulse_d = 1'b0;
    cnt_d   = cnt_q;
    pop     = 1'b0;

    if (flush) begin
      state_d = IDLE;
      instr_d = INSTR_NOP;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            instr_d = head_word;
            cnt_d   = (head_hold == '0) ? '0 : head_hold - HOLD_W'(1);
            pulse_d = 1'b1;
            busy_d  = 1'b1;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - HOLD_W'(1);
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            instr_d = head_word;
            cnt_d   = (head_hold == '0) ? '0 : head_hold - HOLD_W'(1);
            pulse_d = 1'b1;
          end else begin
            instr_d = INSTR_NOP;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          instr_d = INSTR_NOP;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      instr_q     <= INSTR_NOP;
      issue_busy  <= 1'b0;
      issue_pulse <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      issue_busy  <= busy_d;
      issue_pulse <= pulse_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_instruction_issuer.sv
// Scoreboard bench for instruction_issuer: accepted pushes queue expected words and hold
// lengths; a forked monitor checks every issued word and its visible duration.
module tb_instruction_issuer;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_src;
  logic [2:0] in_dst;
  logic [2:0] in_op;
  logic [7:0] in_hold;
  logic [8:0] instruct;
  logic       issue_busy;
  logic       issue_pulse;
  logic [2:0] fifo_count;

  typedef struct {
    logic [8:0]  word;
    int unsigned len;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;

  instruction_issuer #(
    .DEPTH  (4),
    .HOLD_W (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_src      (in_src),
    .in_dst      (in_dst),
    .in_op       (in_op),
    .in_hold     (in_hold),
    .instruct    (instruct),
    .issue_busy  (issue_busy),
    .issue_pulse (issue_pulse),
    .fifo_count  (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction until accepted; expected entry is queued only once accepted
  task automatic push_instr(input logic [2:0] s, input logic [2:0] d, input logic [2:0] o,
                            input logic [7:0] h, output int waited);
    exp_t e;
    waited   = 0;
    in_src   = s;
    in_dst   = d;
    in_op    = o;
    in_hold  = h;
    in_valid = 1'b1;
    while (!in_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      check("push_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      tick();
      in_valid = 1'b0;
      e.word = {o, d, s};
      e.len  = (h == 8'd0) ? 1 : int'(h);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((issue_busy || fifo_count != 3'd0) && n < 500) begin
      tick();
      n++;
    end
    check(name, int'(issue_busy || fifo_count != 3'd0), 0);
  endtask

  task automatic monitor();
    exp_t cur;
    int   run;
    bit   active;
    active = 1'b0;
    run    = 0;
    forever begin
      @(negedge clk);
      if (rst || flush) begin
        exp_q.delete();
        active = 1'b0;
      end else if (issue_pulse) begin
        if (active) check("hold_len", run, int'(cur.len));
        if (exp_q.size() == 0) begin
          check("unexpected_issue", int'(instruct), 0);
          active = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          check("issue_word", int'(instruct), int'(cur.word));
          check("pulse_busy", int'(issue_busy), 1);
          active = 1'b1;
          run    = 1;
        end
      end else if (issue_busy) begin
        if (active) begin
          check("held_word", int'(instruct), int'(cur.word));
          run++;
        end
      end else begin
        if (active) begin
          check("hold_len", run, int'(cur.len));
          active = 1'b0;
        end
        check("idle_nop", int'(instruct), 0);
      end
    end
  endtask

  initial begin
    int w;
    int n;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_src   = '0;
    in_dst   = '0;
    in_op    = '0;
    in_hold  = '0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_instruct", int'(instruct), 0);
    check("rst_busy", int'(issue_busy), 0);
    check("rst_pulse", int'(issue_pulse), 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_ready", int'(in_ready), 1);
    rst = 1'b0;
    tick();

    // Single issue and two-edge latency
    push_instr(3'd4, 3'd6, 3'd7, 8'd10, w);
    check("lat_not_early", int'(instruct), 0);
    check("lat_count", int'(fifo_count), 1);
    tick();
    check("lat_word", int'(instruct), 9'h1F4);
    check("lat_pulse", int'(issue_pulse), 1);
    tick();
    check("pulse_one_cycle", int'(issue_pulse), 0);
    wait_idle("single_idle");
    check("single_end_nop", int'(instruct), 0);

    // Back-to-back with no NOP gap
    push_instr(3'd4, 3'd6, 3'd7, 8'd3, w);
    push_instr(3'd4, 3'd6, 3'd4, 8'd2, w);
    push_instr(3'd4, 3'd3, 3'd3, 8'd1, w);
    n = 0;
    while (issue_busy && n < 100) begin
      n++;
      tick();
    end
    check("b2b_busy_run", n, 5);
    wait_idle("b2b_idle");

    // Full and backpressure
    push_instr(3'd1, 3'd1, 3'd1, 8'd20, w);
    push_instr(3'd2, 3'd1, 3'd1, 8'd1, w);
    push_instr(3'd3, 3'd1, 3'd1, 8'd1, w);
    push_instr(3'd4, 3'd1, 3'd1, 8'd1, w);
    push_instr(3'd5, 3'd1, 3'd1, 8'd2, w);
    check("full_count", int'(fifo_count), 4);
    check("full_ready", int'(in_ready), 0);
    push_instr(3'd6, 3'd1, 3'd1, 8'd1, w);
    check("full_wait", w, 17);
    wait_idle("full_idle");

    // Zero hold treated as one
    push_instr(3'd1, 3'd2, 3'd5, 8'd0, w);
    tick();
    check("hold0_word", int'(instruct), 9'h151);
    tick();
    check("hold0_gone", int'(instruct), 0);
    wait_idle("hold0_idle");

    // Flush mid-hold with two queued and a same-cycle push
    push_instr(3'd4, 3'd6, 3'd7, 8'd10, w);
    push_instr(3'd1, 3'd1, 3'd1, 8'd3, w);
    push_instr(3'd2, 3'd2, 3'd2, 8'd3, w);
    check("pre_flush_count", int'(fifo_count), 2);
    check("pre_flush_word", int'(instruct), 9'h1F4);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_src   = 3'd7;
    in_dst   = 3'd7;
    in_op    = 3'd7;
    in_hold  = 8'd5;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_word", int'(instruct), 0);
    check("flush_count", int'(fifo_count), 0);
    check("flush_busy", int'(issue_busy), 0);
    repeat (3) tick();
    check("flush_drop", int'(fifo_count), 0);

    // Reset mid-hold
    push_instr(3'd4, 3'd6, 3'd7, 8'd10, w);
    push_instr(3'd1, 3'd2, 3'd3, 8'd4, w);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_word", int'(instruct), 0);
    check("mid_rst_busy", int'(issue_busy), 0);
    check("mid_rst_count", int'(fifo_count), 0);
    check("mid_rst_ready", int'(in_ready), 1);
    repeat (3) tick();
    check("mid_rst_stay", int'(instruct), 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_issuer.md
Name: instruction_issuer

Overview:
Transmit-side counterpart of instruction_decoder. Accepts instruction fields (source select, destination select, opcode, hold time) over a valid/ready interface and buffers them in a small FIFO. Packs each entry into the 9-bit instruct word and drives it onto the decoder's instruct bus for a programmable number of cycles. Replaces hand-written stimulus sequences with a clocked, queue-driven issuer.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
HOLD_W, 8, width of per-instruction hold count.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  synchronous clear: empties the FIFO and aborts the current word
in_valid  input  1  producer has an instruction
in_ready  output  1  issuer can accept; equals !full
in_src  input  3  input select, packed to instruct[2:0]
in_dst  input  3  output select, packed to instruct[5:3]
in_op  input  3  opcode, packed to instruct[8:6]
in_hold  input  HOLD_W  cycles to hold the word; 0 is treated as 1
instruct  output  9  registered instruction word to the decoder
issue_busy  output  1  high while a word is being held
issue_pulse  output  1  one-cycle strobe on the first cycle each new word is driven
fifo_count  output  $clog2(DEPTH)+1  entries currently queued

Behaviour:
- Reset (rst=1 at an edge): FIFO empty; instruct=9'h000 (NOP); issue_busy=0; issue_pulse=0; fifo_count=0; state=IDLE; hold counter=0. Reset takes priority over all other inputs, including mid-hold.
- Push: occurs when in_valid && in_ready at the edge. The entry stores {op,dst,src,hold}. in_ready is low when fifo_count==DEPTH; a push cannot occur while full, even if a pop happens in the same cycle.
- Simultaneous push and pop when not full: both take effect; fifo_count is unchanged.
- FSM IDLE:
  - If the FIFO is non-empty, pop the head at the edge.
  - instruct <= {op,dst,src}; hold counter <= max(hold,1)-1; issue_pulse <= 1; issue_busy <= 1; go to HOLD.
  - If the FIFO is empty, instruct stays at NOP.
- FSM HOLD:
  - Counter non-zero: decrement; instruct unchanged; issue_pulse <= 0.
  - Counter==0 and FIFO non-empty: pop and load the next word at the same edge (back-to-back, no NOP gap); issue_pulse <= 1.
  - Counter==0 and FIFO empty: instruct <= NOP; issue_busy <= 0; go to IDLE.
- Hold time: each word is visible on instruct for exactly max(in_hold,1) consecutive cycles.
- Latency: an entry pushed at edge t into an empty FIFO while IDLE appears on instruct after edge t+1. There is no combinational bypass.
- flush (not in reset):
  - At the edge: FIFO cleared, instruct <= NOP, issue_busy <= 0, issue_pulse <= 0, state <= IDLE.
  - A push in the same cycle as flush is dropped.
  - in_ready stays as computed from the current count.
- FIFO pointers: $clog2(DEPTH) bits, wrapping naturally. The count is kept separately so that full and empty are unambiguous.
- FIFO storage needs no reset; only pointers and count reset.
- All outputs are registered except in_ready, which is a combinational compare of the count register.

Decomposition:
- Shared package instr_pkg:
  - typedef instr_t as a packed struct {op[2:0], dst[2:0], src[2:0]}, MSB→LSB, 9 bits, matching the decoder's instruct layout.
  - localparam SEL_W=3, OP_W=3.
  - localparam instr_t INSTR_NOP='0.
  - FSM state enum {IDLE, HOLD}.
- Sub-module instr_fifo:
  - Parameterised by DEPTH and entry width.
  - Synchronous push, pop, clear.
  - Outputs full, empty, count, head data (show-ahead).
- Top level: FSM, hold counter and output registers.

Test Plan:
- Reset mid-hold: load src=4, dst=6, op=7, hold=10; assert rst at cycle 5 → next cycle instruct=0x000, issue_busy=0, fifo_count=0, in_ready=1.
- Single issue: push src=4, dst=6, op=7, hold=10 while IDLE → instruct=0x1F4 two edges after push, held exactly 10 cycles, issue_pulse high for 1 cycle, then instruct=0x000 and issue_busy=0.
- Back-to-back: push (4,6,7,hold=3), (4,6,4,hold=2), (4,3,3,hold=1) → instruct sequence 0x1F4×3, 0x134×2, 0x0DC×1, then NOP. No gap cycles; three issue_pulse strobes.
- Full/backpressure (DEPTH=4): hold first word 20 cycles and attempt 6 pushes → 5 accepted (1 issuing plus 4 queued), in_ready=0 while fifo_count=4. The 6th is accepted only after the next pop, with no loss or duplication.
- hold=0: push (1,2,5,hold=0) → instruct=0x151 for exactly 1 cycle.
- flush: flush during the hold of 0x1F4 with 2 entries queued, plus a push in the same cycle → next cycle instruct=0x000, fifo_count=0, and the pushed entry never appears.
